// File: rtl/chaining_record_table_pkg.sv
// Shared types, sizing constants and the element-bit helper for the chaining
// record table and its per-slot entries.
package chaining_pkg;

   localparam int RECORDS     = 4;
   localparam int WRITE_PORTS = 2;
   localparam int REG_GROUP   = 8;
   localparam int OFFSETS     = 4;
   localparam int MASK_W      = REG_GROUP * OFFSETS;
   localparam int IDX_W       = 3;
   localparam int VD_W        = 5;
   localparam int OFF_W       = 2;
   localparam int BIT_IDX_W   = $clog2(MASK_W);

   typedef struct packed {
      logic              vd_valid;
      logic [VD_W-1:0]   vd;
      logic [IDX_W-1:0]  instIndex;
      logic [MASK_W-1:0] elementMask;
   } chaining_record_t;

   typedef struct packed {
      logic                 hit;
      logic [BIT_IDX_W-1:0] index;
   } elem_bit_t;

   // Register distance wraps modulo 32, so a write below vd lands far above
   // the group and misses.
   function automatic elem_bit_t elem_bit(input logic [VD_W-1:0]  vs,
                                          input logic [VD_W-1:0]  vd,
                                          input logic [OFF_W-1:0] offset);
      logic [VD_W-1:0] rel;
      elem_bit_t       res;
      rel       = vs - vd;
      res.hit   = (rel < VD_W'(REG_GROUP));
      res.index = {rel[2:0], offset};
      return res;
   endfunction

endpackage

// File: rtl/chaining_record_table_if.sv
// Allocation, write-completion, finish and flattened record signals of the
// chaining record table, bundled for connection to the issue/VRF side.
interface chaining_record_table_if;
   import chaining_pkg::*;

   logic                          alloc_valid;
   logic                          alloc_ready;
   logic                          alloc_vd_valid;
   logic [VD_W-1:0]               alloc_vd;
   logic [IDX_W-1:0]              alloc_instIndex;

   logic [WRITE_PORTS-1:0]        write_valid;
   logic [WRITE_PORTS*VD_W-1:0]   write_vs;
   logic [WRITE_PORTS*OFF_W-1:0]  write_offset;
   logic [WRITE_PORTS*IDX_W-1:0]  write_instIndex;

   logic                          finish_valid;
   logic [IDX_W-1:0]              finish_instIndex;

   logic [RECORDS-1:0]            record_vd_valid;
   logic [RECORDS*VD_W-1:0]       record_vd;
   logic [RECORDS*IDX_W-1:0]      record_instIndex;
   logic [RECORDS*MASK_W-1:0]     record_elementMask;
   logic [RECORDS-1:0]            record_valid;
   logic                          dup_error;

   modport master (
      output alloc_valid, alloc_vd_valid, alloc_vd, alloc_instIndex,
      output write_valid, write_vs, write_offset, write_instIndex,
      output finish_valid, finish_instIndex,
      input  alloc_ready, record_vd_valid, record_vd, record_instIndex,
      input  record_elementMask, record_valid, dup_error
   );

   modport slave (
      input  alloc_valid, alloc_vd_valid, alloc_vd, alloc_instIndex,
      input  write_valid, write_vs, write_offset, write_instIndex,
      input  finish_valid, finish_instIndex,
      output alloc_ready, record_vd_valid, record_vd, record_instIndex,
      output record_elementMask, record_valid, dup_error
   );

endinterface

// File: rtl/chaining_record_table_entry.sv
// One chaining record slot: loads on allocation, accumulates element-written
// bits from matching VRF write completions, and drops valid on finish.
module chaining_record_entry
   import chaining_pkg::*;
(
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         alloc_en,
   input  chaining_record_t             alloc_rec,
   input  logic [WRITE_PORTS-1:0]       write_valid,
   input  logic [WRITE_PORTS*VD_W-1:0]  write_vs,
   input  logic [WRITE_PORTS*OFF_W-1:0] write_offset,
   input  logic [WRITE_PORTS*IDX_W-1:0] write_instIndex,
   input  logic                         finish_valid,
   input  logic [IDX_W-1:0]             finish_instIndex,
   output chaining_record_t             rec,
   output logic                         valid
);

   chaining_record_t  rec_q, rec_d;
   logic              valid_q, valid_d;
   logic [MASK_W-1:0] set_mask;
   elem_bit_t         eb;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves
      // it unassigned and a latch is never inferred.
      rec_d    = rec_q;
      valid_d  = valid_q;
      set_mask = '0;
      eb       = '0;

      // Ports hitting the same slot simply OR their bits together.
      for (int p = 0; p < WRITE_PORTS; p++) begin
         if (write_valid[p] && valid_q && rec_q.vd_valid &&
             (write_instIndex[p*IDX_W +: IDX_W] == rec_q.instIndex)) begin
            eb = elem_bit(write_vs[p*VD_W +: VD_W], rec_q.vd,
                          write_offset[p*OFF_W +: OFF_W]);
            if (eb.hit) set_mask[eb.index] = 1'b1;
         end
      end
      rec_d.elementMask = rec_q.elementMask | set_mask;

      if (finish_valid && valid_q && (finish_instIndex == rec_q.instIndex))
         valid_d = 1'b0;

      // Only a free slot is ever selected, so this never races a finish.
      if (alloc_en) begin
         rec_d             = alloc_rec;
         rec_d.elementMask = '0;
         valid_d           = 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rec_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         rec_q   <= rec_d;
         valid_q <= valid_d;
      end
   end

   assign rec   = rec_q;
   assign valid = valid_q;

endmodule

// File: rtl/chaining_record_table.sv
// Live chaining record table: picks the lowest free slot for each allocation,
// flags duplicate live instruction indices, and flattens slot state for checkers.
module chaining_record_table
   import chaining_pkg::*;
(
   input  logic                    clock,
   input  logic                    reset,
   chaining_record_table_if.slave  bus
);

   chaining_record_t rec [RECORDS];
   logic [RECORDS-1:0] valid;
   logic [RECORDS-1:0] alloc_sel;
   logic               found;
   logic               alloc_ready;
   logic               alloc_fire;
   logic               dup_hit;
   logic               dup_error_q, dup_error_d;
   chaining_record_t   alloc_rec;

   logic [RECORDS-1:0]        flat_vd_valid;
   logic [RECORDS*VD_W-1:0]   flat_vd;
   logic [RECORDS*IDX_W-1:0]  flat_idx;
   logic [RECORDS*MASK_W-1:0] flat_mask;

   // Ready depends on registered valid bits only; a slot freed this cycle is
   // not offered until the next one.
   assign alloc_ready = ~&valid;
   assign alloc_fire  = bus.alloc_valid & alloc_ready;

   always_comb begin
      alloc_sel = '0;
      found     = 1'b0;
      dup_hit   = 1'b0;
      for (int i = 0; i < RECORDS; i++) begin
         if (!valid[i] && !found) begin
            alloc_sel[i] = 1'b1;
            found        = 1'b1;
         end
         if (valid[i] && (rec[i].instIndex == bus.alloc_instIndex))
            dup_hit = 1'b1;
      end
      dup_error_d = dup_error_q | (alloc_fire & dup_hit);
   end

   always_comb begin
      alloc_rec             = '0;
      alloc_rec.vd_valid    = bus.alloc_vd_valid;
      alloc_rec.vd          = bus.alloc_vd;
      alloc_rec.instIndex   = bus.alloc_instIndex;
   end

   for (genvar g = 0; g < RECORDS; g++) begin : g_entry
      chaining_record_entry u_entry (
         .clock            (clock),
         .reset            (reset),
         .alloc_en         (alloc_fire & alloc_sel[g]),
         .alloc_rec        (alloc_rec),
         .write_valid      (bus.write_valid),
         .write_vs         (bus.write_vs),
         .write_offset     (bus.write_offset),
         .write_instIndex  (bus.write_instIndex),
         .finish_valid     (bus.finish_valid),
         .finish_instIndex (bus.finish_instIndex),
         .rec              (rec[g]),
         .valid            (valid[g])
      );
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) dup_error_q <= 1'b0;
      else        dup_error_q <= dup_error_d;
   end

   always_comb begin
      flat_vd_valid = '0;
      flat_vd       = '0;
      flat_idx      = '0;
      flat_mask     = '0;
      for (int i = 0; i < RECORDS; i++) begin
         flat_vd_valid[i]               = rec[i].vd_valid;
         flat_vd[i*VD_W +: VD_W]        = rec[i].vd;
         flat_idx[i*IDX_W +: IDX_W]     = rec[i].instIndex;
         flat_mask[i*MASK_W +: MASK_W]  = rec[i].elementMask;
      end
   end

   assign bus.alloc_ready        = alloc_ready;
   assign bus.record_valid       = valid;
   assign bus.record_vd_valid    = flat_vd_valid;
   assign bus.record_vd          = flat_vd;
   assign bus.record_instIndex   = flat_idx;
   assign bus.record_elementMask = flat_mask;
   assign bus.dup_error          = dup_error_q;

endmodule

// File: tb/tb_chaining_record_table.sv
// Directed and random checks of the chaining record table against a
// slot-array reference model built from the table's behavioural rules.
module tb_chaining_record_table;
   import chaining_pkg::*;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   chaining_record_table_if bus ();

   chaining_record_table dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus.slave)
   );

   int total = 0;
   int bad   = 0;

   bit          m_valid [RECORDS];
   bit          m_vdv   [RECORDS];
   int          m_vd    [RECORDS];
   int          m_idx   [RECORDS];
   logic [31:0] m_mask  [RECORDS];
   bit          m_dup;

   bit          n_valid [RECORDS];
   bit          n_vdv   [RECORDS];
   int          n_vd    [RECORDS];
   int          n_idx   [RECORDS];
   logic [31:0] n_mask  [RECORDS];
   bit          n_dup;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < RECORDS; i++) begin
         m_valid[i] = 0; m_vdv[i] = 0; m_vd[i] = 0; m_idx[i] = 0; m_mask[i] = '0;
      end
      m_dup = 0;
   endtask

   task automatic idle();
      bus.alloc_valid      = 1'b0;
      bus.alloc_vd_valid   = 1'b0;
      bus.alloc_vd         = '0;
      bus.alloc_instIndex  = '0;
      bus.write_valid      = '0;
      bus.write_vs         = '0;
      bus.write_offset     = '0;
      bus.write_instIndex  = '0;
      bus.finish_valid     = 1'b0;
      bus.finish_instIndex = '0;
   endtask

   task automatic set_alloc(input int vdv, input int vd, input int idx);
      bus.alloc_valid     = 1'b1;
      bus.alloc_vd_valid  = 1'(vdv);
      bus.alloc_vd        = 5'(vd);
      bus.alloc_instIndex = 3'(idx);
   endtask

   task automatic set_write(input int p, input int vs, input int off, input int idx);
      bus.write_valid[p]                = 1'b1;
      bus.write_vs[p*VD_W +: VD_W]       = 5'(vs);
      bus.write_offset[p*OFF_W +: OFF_W] = 2'(off);
      bus.write_instIndex[p*IDX_W +: IDX_W] = 3'(idx);
   endtask

   task automatic set_finish(input int idx);
      bus.finish_valid     = 1'b1;
      bus.finish_instIndex = 3'(idx);
   endtask

   // Next state from the rules: writes only touch slots already live, finish
   // clears the matching live slot, allocation takes the lowest free slot.
   task automatic model_next();
      int slot;
      int rel;
      slot = -1;
      for (int i = 0; i < RECORDS; i++) begin
         n_valid[i] = m_valid[i]; n_vdv[i] = m_vdv[i]; n_vd[i] = m_vd[i];
         n_idx[i] = m_idx[i]; n_mask[i] = m_mask[i];
      end
      n_dup = m_dup;
      for (int p = 0; p < WRITE_PORTS; p++) begin
         if (bus.write_valid[p]) begin
            for (int i = 0; i < RECORDS; i++) begin
               if (m_valid[i] && m_vdv[i] &&
                   m_idx[i] == int'(bus.write_instIndex[p*IDX_W +: IDX_W])) begin
                  rel = (int'(bus.write_vs[p*VD_W +: VD_W]) - m_vd[i] + 32) % 32;
                  if (rel < 8)
                     n_mask[i][rel*4 + int'(bus.write_offset[p*OFF_W +: OFF_W])] = 1'b1;
               end
            end
         end
      end
      if (bus.finish_valid)
         for (int i = 0; i < RECORDS; i++)
            if (m_valid[i] && m_idx[i] == int'(bus.finish_instIndex)) n_valid[i] = 0;
      if (bus.alloc_valid)
         for (int i = RECORDS - 1; i >= 0; i--)
            if (!m_valid[i]) slot = i;
      if (slot >= 0) begin
         for (int i = 0; i < RECORDS; i++)
            if (m_valid[i] && m_idx[i] == int'(bus.alloc_instIndex)) n_dup = 1;
         n_valid[slot] = 1;
         n_vdv[slot]   = bus.alloc_vd_valid;
         n_vd[slot]    = int'(bus.alloc_vd);
         n_idx[slot]   = int'(bus.alloc_instIndex);
         n_mask[slot]  = '0;
      end
   endtask

   task automatic check_all();
      logic [RECORDS-1:0] ev;
      bit any_free;
      any_free = 0;
      for (int i = 0; i < RECORDS; i++) begin
         ev[i] = m_valid[i];
         if (!m_valid[i]) any_free = 1;
      end
      chk("record_valid", 64'(bus.record_valid), 64'(ev));
      chk("alloc_ready", 64'(bus.alloc_ready), 64'(any_free));
      chk("dup_error", 64'(bus.dup_error), 64'(m_dup));
      for (int i = 0; i < RECORDS; i++) begin
         if (m_valid[i]) begin
            chk($sformatf("vd_valid%0d", i), 64'(bus.record_vd_valid[i]), 64'(m_vdv[i]));
            chk($sformatf("vd%0d", i), 64'(bus.record_vd[i*VD_W +: VD_W]), 64'(m_vd[i]));
            chk($sformatf("idx%0d", i), 64'(bus.record_instIndex[i*IDX_W +: IDX_W]), 64'(m_idx[i]));
            chk($sformatf("mask%0d", i), 64'(bus.record_elementMask[i*MASK_W +: MASK_W]), 64'(m_mask[i]));
         end
      end
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_valid"}, 64'(bus.record_valid), 64'd0);
      chk({tag, "_vd_valid"}, 64'(bus.record_vd_valid), 64'd0);
      chk({tag, "_vd"}, 64'(bus.record_vd), 64'd0);
      chk({tag, "_idx"}, 64'(bus.record_instIndex), 64'd0);
      chk({tag, "_mask"}, 64'(|bus.record_elementMask), 64'd0);
      chk({tag, "_dup"}, 64'(bus.dup_error), 64'd0);
   endtask

   task automatic cycle();
      model_next();
      @(posedge clock);
      #1;
      for (int i = 0; i < RECORDS; i++) begin
         m_valid[i] = n_valid[i]; m_vdv[i] = n_vdv[i]; m_vd[i] = n_vd[i];
         m_idx[i] = n_idx[i]; m_mask[i] = n_mask[i];
      end
      m_dup = n_dup;
      check_all();
      idle();
   endtask

   task automatic rand_inputs();
      int s;
      idle();
      if ($urandom_range(0, 1) == 1)
         set_alloc(($urandom_range(0, 7) != 0) ? 1 : 0, $urandom_range(0, 31), $urandom_range(0, 7));
      for (int p = 0; p < WRITE_PORTS; p++) begin
         if ($urandom_range(0, 3) != 0) begin
            s = $urandom_range(0, RECORDS - 1);
            set_write(p, (m_vd[s] + $urandom_range(0, 10) + 31) % 32, $urandom_range(0, 3),
                      ($urandom_range(0, 3) != 0) ? m_idx[s] : $urandom_range(0, 7));
         end
      end
      if ($urandom_range(0, 4) == 0) begin
         s = $urandom_range(0, RECORDS - 1);
         set_finish(($urandom_range(0, 3) != 0) ? m_idx[s] : $urandom_range(0, 7));
      end
   endtask

   initial begin
      idle();
      model_reset();
      #1;
      check_zero("reset");
      #11 reset = 1'b1;
      @(posedge clock);
      #1;
      chk("ready_after_reset", 64'(bus.alloc_ready), 64'd1);

      // First allocation lands in slot 0 with an empty mask.
      set_alloc(1, 8, 1);
      cycle();
      chk("first_valid", 64'(bus.record_valid), 64'h1);
      chk("first_vd", 64'(bus.record_vd[4:0]), 64'd8);
      chk("first_mask", 64'(bus.record_elementMask[31:0]), 64'd0);

      // Two ports on the same slot: rel 1 offset 2 and rel 0 offset 0.
      set_write(0, 9, 2, 1);
      set_write(1, 8, 0, 1);
      cycle();
      chk("two_port_mask", 64'(bus.record_elementMask[31:0]), 64'h41);

      // Below-base wrap, rel 8 and a foreign index all miss.
      set_write(0, 7, 3, 1);
      set_write(1, 16, 1, 1);
      cycle();
      set_write(0, 10, 1, 2);
      cycle();
      chk("miss_mask", 64'(bus.record_elementMask[31:0]), 64'h41);

      // Alloc alongside a write to the new index: the new slot stays clean.
      set_alloc(1, 12, 4);
      set_write(0, 12, 0, 4);
      cycle();
      chk("alloc_write_mask", 64'(bus.record_elementMask[63:32]), 64'd0);
      set_finish(1);
      cycle();
      set_finish(4);
      cycle();

      // Fill the table, then finish slot 2 while a request is pending.
      for (int k = 0; k < RECORDS; k++) begin
         set_alloc(1, 4 * k, k);
         cycle();
      end
      chk("full_ready", 64'(bus.alloc_ready), 64'd0);
      set_alloc(1, 20, 5);
      set_finish(2);
      set_write(0, 8, 1, 2);
      cycle();
      chk("freed_valid", 64'(bus.record_valid), 64'hb);
      set_alloc(1, 24, 6);
      cycle();
      chk("refill_valid", 64'(bus.record_valid), 64'hf);
      chk("refill_mask", 64'(bus.record_elementMask[95:64]), 64'd0);
      for (int k = 0; k < RECORDS; k++) begin
         set_finish(m_idx[k]);
         cycle();
      end

      // Duplicate live index raises the sticky error.
      set_alloc(1, 3, 1);
      cycle();
      set_alloc(1, 5, 1);
      cycle();
      chk("dup_set", 64'(bus.dup_error), 64'd1);
      chk("dup_slot1", 64'(bus.record_valid), 64'h3);

      for (int n = 0; n < 400; n++) begin
         rand_inputs();
         cycle();
      end
      chk("dup_sticky", 64'(bus.dup_error), 64'd1);

      // Populate, then drop reset mid-stream with writes in flight.
      for (int k = 0; k < RECORDS; k++) begin
         set_finish(m_idx[k]);
         cycle();
      end
      set_alloc(1, 2, 3);
      cycle();
      set_write(0, 4, 1, 3);
      cycle();
      set_write(0, 5, 2, 3);
      set_write(1, 2, 3, 3);
      reset = 1'b0;
      #1;
      check_zero("mid_reset");
      @(posedge clock);
      #1;
      check_zero("held_reset");
      idle();
      reset = 1'b1;
      model_reset();
      cycle();
      check_zero("post_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
